// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit
// Tracks in-flight register writes for DEPTH post-issue stages, forwards the
// youngest matching producer result to each of NUM_SRC source operands, and
// raises stall_o on a load-use hazard. The stall inserts a bubble into the
// tracking pipe. stall_cnt_o counts stall cycles and saturates.
//
// Decode handshake: issue_valid_i is the valid and !stall_o is the ready. An
// instruction leaves decode on a clock edge where advance_i=1,
// issue_valid_i=1, stall_o=0 and flush_i=0. On any other advancing edge the
// pipe takes a bubble in entry 0.
module operand_bypass_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          advance_i,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_we_i,
  input  logic                          issue_late_i,
  input  logic [REG_ADDR_W-1:0]         issue_rd_i,
  input  logic [NUM_SRC-1:0]            src_used_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]       rf_data_i,
  input  logic [DEPTH*XLEN-1:0]         stage_data_i,
  output logic [NUM_SRC*XLEN-1:0]       op_o,
  output logic [NUM_SRC*4-1:0]          sel_o,
  output logic                          stall_o,
  output logic [31:0]                   stall_cnt_o
);

  // Tracking entries: entry 0 is the youngest (EX/MEM).
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      late_q, late_d;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]    hazard;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_ADDR_W-1:0] addr;
    logic                  hit;
    logic                  win_avail;
    logic [3:0]            win;
    logic [XLEN-1:0]       win_data;

    assign addr = src_addr_i[s*REG_ADDR_W +: REG_ADDR_W];

    // Scan oldest to youngest so the youngest matching entry is the last writer.
    always_comb begin
      hit       = 1'b0;
      win       = '0;
      win_avail = 1'b1;
      win_data  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && (rd_q[k] == addr) && (addr != '0)) begin
          hit       = 1'b1;
          win       = 4'(k);
          win_avail = (k != 0) || !late_q[k];
          win_data  = stage_data_i[k*XLEN +: XLEN];
        end
      end
    end

    assign hazard[s]             = src_used_i[s] && hit && !win_avail;
    assign op_o[s*XLEN +: XLEN]  = (hit && win_avail) ? win_data
                                                      : rf_data_i[s*XLEN +: XLEN];
    assign sel_o[s*4 +: 4]       = hit ? (win + 4'd1) : 4'd0;
  end

  assign stall_o     = issue_valid_i && (|hazard);
  assign stall_cnt_o = stall_cnt_q;

  // Next state: shift the tracking pipe on advance, bubble on stall or flush.
  always_comb begin
    valid_d     = valid_q;
    late_d      = late_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    if (advance_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        late_d[k]  = late_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      valid_d[0] = issue_valid_i && issue_we_i && !stall_o && !flush_i;
      late_d[0]  = issue_late_i;
      rd_d[0]    = issue_rd_i;
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  // State registers; reset clears validity and the stall counter only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
    late_q <= late_d;
    rd_q   <= rd_d;
  end

endmodule
